// File: rtl/core_alu_pkg.sv
// Shared widths, op codes and FSM encodings for the core ALU scheduler.
// Op code order matches the one-hot flag order expected by core_alu.
package core_alu_pkg;

   localparam int XLEN  = 32;
   localparam int OP_W  = 6;
   localparam int N_OPS = 37;

   localparam logic [OP_W-1:0] OP_ADDI  = 6'd0;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'd1;
   localparam logic [OP_W-1:0] OP_SLTIU = 6'd2;
   localparam logic [OP_W-1:0] OP_XORI  = 6'd3;
   localparam logic [OP_W-1:0] OP_ORI   = 6'd4;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'd5;
   localparam logic [OP_W-1:0] OP_SLLI  = 6'd6;
   localparam logic [OP_W-1:0] OP_SRLI  = 6'd7;
   localparam logic [OP_W-1:0] OP_SRAI  = 6'd8;
   localparam logic [OP_W-1:0] OP_ADD   = 6'd9;
   localparam logic [OP_W-1:0] OP_SUB   = 6'd10;
   localparam logic [OP_W-1:0] OP_SLL   = 6'd11;
   localparam logic [OP_W-1:0] OP_SLT   = 6'd12;
   localparam logic [OP_W-1:0] OP_SLTU  = 6'd13;
   localparam logic [OP_W-1:0] OP_XOR   = 6'd14;
   localparam logic [OP_W-1:0] OP_SRL   = 6'd15;
   localparam logic [OP_W-1:0] OP_SRA   = 6'd16;
   localparam logic [OP_W-1:0] OP_OR    = 6'd17;
   localparam logic [OP_W-1:0] OP_AND   = 6'd18;
   localparam logic [OP_W-1:0] OP_LUI   = 6'd19;
   localparam logic [OP_W-1:0] OP_AUIPC = 6'd20;
   localparam logic [OP_W-1:0] OP_JAL   = 6'd21;
   localparam logic [OP_W-1:0] OP_JALR  = 6'd22;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'd23;
   localparam logic [OP_W-1:0] OP_BNE   = 6'd24;
   localparam logic [OP_W-1:0] OP_BLT   = 6'd25;
   localparam logic [OP_W-1:0] OP_BGE   = 6'd26;
   localparam logic [OP_W-1:0] OP_BLTU  = 6'd27;
   localparam logic [OP_W-1:0] OP_BGEU  = 6'd28;
   localparam logic [OP_W-1:0] OP_LB    = 6'd29;
   localparam logic [OP_W-1:0] OP_LH    = 6'd30;
   localparam logic [OP_W-1:0] OP_LW    = 6'd31;
   localparam logic [OP_W-1:0] OP_LBU   = 6'd32;
   localparam logic [OP_W-1:0] OP_LHU   = 6'd33;
   localparam logic [OP_W-1:0] OP_SB    = 6'd34;
   localparam logic [OP_W-1:0] OP_SH    = 6'd35;
   localparam logic [OP_W-1:0] OP_SW    = 6'd36;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef enum logic {
      OWN_EX = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

   function automatic logic op_in_range(input logic [OP_W-1:0] op);
      return op < OP_W'(N_OPS);
   endfunction

endpackage

// File: rtl/core_alu_opdec.sv
// Op code to one-hot ALU flag decoder; codes outside the op table decode to zero.
module core_alu_opdec
   import core_alu_pkg::*;
(
   input  logic [OP_W-1:0]  op,
   output logic [N_OPS-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < N_OPS; i++) begin
         onehot[i] = (op == OP_W'(i));
      end
   end

endmodule

// File: rtl/core_alu_sched.sv
// Round-robin scheduler sharing one core_alu between the EX and LS requesters.
//   state   | meaning
//   IDLE    | no op owned; grants at most one requester per cycle
//   EXEC    | operands and op flags held while the ALU works, cnt counts down
//   RESP    | sampled result offered to the owner until it is consumed
module core_alu_sched
   import core_alu_pkg::*;
#(
   parameter int ALU_LAT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             ex_req_valid,
   output logic             ex_req_ready,
   input  logic [OP_W-1:0]  ex_req_op,
   input  logic [XLEN-1:0]  ex_req_rs1,
   input  logic [XLEN-1:0]  ex_req_rs2,
   input  logic [XLEN-1:0]  ex_req_imm,
   output logic             ex_rsp_valid,
   input  logic             ex_rsp_ready,
   output logic [XLEN-1:0]  ex_rsp_result,
   input  logic             ls_req_valid,
   output logic             ls_req_ready,
   input  logic [OP_W-1:0]  ls_req_op,
   input  logic [XLEN-1:0]  ls_req_rs1,
   input  logic [XLEN-1:0]  ls_req_rs2,
   input  logic [XLEN-1:0]  ls_req_imm,
   output logic             ls_rsp_valid,
   input  logic             ls_rsp_ready,
   output logic [XLEN-1:0]  ls_rsp_result,
   output logic [N_OPS-1:0] alu_op_onehot,
   output logic [XLEN-1:0]  alu_rs1,
   output logic [XLEN-1:0]  alu_rs2,
   output logic [XLEN-1:0]  alu_imm,
   input  logic [XLEN-1:0]  alu_result,
   output logic             busy
);

   localparam int CNT_W = $clog2(ALU_LAT + 1);

   logic [1:0]       state_q;
   logic [CNT_W-1:0] cnt_q;
   owner_e           owner_q;
   owner_e           last_grant_q;
   logic [OP_W-1:0]  op_q;
   logic [XLEN-1:0]  rs1_q;
   logic [XLEN-1:0]  rs2_q;
   logic [XLEN-1:0]  imm_q;
   logic [XLEN-1:0]  result_q;
   logic [N_OPS-1:0] dec_onehot;

   logic             can_grant;
   logic             grant_ex;
   logic             grant_ls;
   logic             accept;
   logic             rsp_fire;
   logic [OP_W-1:0]  sel_op;
   logic [XLEN-1:0]  sel_rs1;
   logic [XLEN-1:0]  sel_rs2;
   logic [XLEN-1:0]  sel_imm;

   // A tie goes to whichever requester was not served last.
   assign can_grant = (state_q == ST_IDLE) && !flush && !rst;
   assign grant_ex  = can_grant && ex_req_valid && (!ls_req_valid || last_grant_q == OWN_LS);
   assign grant_ls  = can_grant && ls_req_valid && (!ex_req_valid || last_grant_q == OWN_EX);
   assign accept    = grant_ex || grant_ls;

   assign ex_req_ready = grant_ex;
   assign ls_req_ready = grant_ls;

   assign sel_op  = grant_ls ? ls_req_op  : ex_req_op;
   assign sel_rs1 = grant_ls ? ls_req_rs1 : ex_req_rs1;
   assign sel_rs2 = grant_ls ? ls_req_rs2 : ex_req_rs2;
   assign sel_imm = grant_ls ? ls_req_imm : ex_req_imm;

   core_alu_opdec u_opdec (
      .op     (op_q),
      .onehot (dec_onehot)
   );

   assign alu_op_onehot = (state_q == ST_EXEC) ? dec_onehot : '0;
   assign alu_rs1       = rs1_q;
   assign alu_rs2       = rs2_q;
   assign alu_imm       = imm_q;

   assign ex_rsp_valid  = (state_q == ST_RESP) && (owner_q == OWN_EX);
   assign ls_rsp_valid  = (state_q == ST_RESP) && (owner_q == OWN_LS);
   assign ex_rsp_result = result_q;
   assign ls_rsp_result = result_q;
   assign rsp_fire      = (ex_rsp_valid && ex_rsp_ready) || (ls_rsp_valid && ls_rsp_ready);

   assign busy = (state_q != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         owner_q      <= OWN_EX;
         last_grant_q <= OWN_LS;
         op_q         <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         imm_q        <= '0;
         result_q     <= '0;
      end else if (flush) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q         <= sel_op;
                  rs1_q        <= sel_rs1;
                  rs2_q        <= sel_rs2;
                  imm_q        <= sel_imm;
                  owner_q      <= grant_ls ? OWN_LS : OWN_EX;
                  last_grant_q <= grant_ls ? OWN_LS : OWN_EX;
                  cnt_q        <= CNT_W'(ALU_LAT - 1);
                  state_q      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (cnt_q == '0) begin
                  // Unknown op codes never reach the ALU, so their result is forced.
                  result_q <= op_in_range(op_q) ? alu_result : '0;
                  state_q  <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_RESP: begin
               if (rsp_fire) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_alu_sched.sv
// Bench for core_alu_sched: vector table, hand sequences and a random run against a transaction model.
module tb_core_alu_sched;
   import core_alu_pkg::*;

   localparam int LAT = 3;

   logic             clk = 1'b0;
   logic             rst, flush;
   logic             ex_req_valid, ex_req_ready, ex_rsp_valid, ex_rsp_ready;
   logic [OP_W-1:0]  ex_req_op;
   logic [XLEN-1:0]  ex_req_rs1, ex_req_rs2, ex_req_imm, ex_rsp_result;
   logic             ls_req_valid, ls_req_ready, ls_rsp_valid, ls_rsp_ready;
   logic [OP_W-1:0]  ls_req_op;
   logic [XLEN-1:0]  ls_req_rs1, ls_req_rs2, ls_req_imm, ls_rsp_result;
   logic [N_OPS-1:0] alu_op_onehot;
   logic [XLEN-1:0]  alu_rs1, alu_rs2, alu_imm, alu_result;
   logic             busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   core_alu_sched #(.ALU_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .ex_req_valid(ex_req_valid), .ex_req_ready(ex_req_ready), .ex_req_op(ex_req_op),
      .ex_req_rs1(ex_req_rs1), .ex_req_rs2(ex_req_rs2), .ex_req_imm(ex_req_imm),
      .ex_rsp_valid(ex_rsp_valid), .ex_rsp_ready(ex_rsp_ready), .ex_rsp_result(ex_rsp_result),
      .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_op(ls_req_op),
      .ls_req_rs1(ls_req_rs1), .ls_req_rs2(ls_req_rs2), .ls_req_imm(ls_req_imm),
      .ls_rsp_valid(ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready), .ls_rsp_result(ls_rsp_result),
      .alu_op_onehot(alu_op_onehot), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm),
      .alu_result(alu_result), .busy(busy)
   );

   // Behaviour of the stub ALU for each op code.
   function automatic logic [31:0] op_value(input logic [5:0] op, input logic [31:0] a, b, c);
      case (op)
         OP_ADDI, OP_JALR, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return a + c;
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_XOR:  return a ^ b;
         OP_OR:   return a | b;
         OP_AND:  return a & b;
         OP_XORI: return a ^ c;
         OP_ORI:  return a | c;
         OP_ANDI: return a & c;
         OP_SLL:  return a << b[4:0];
         OP_SRL:  return a >> b[4:0];
         default: return a ^ b ^ c ^ 32'h5A5A0000;
      endcase
   endfunction

   function automatic logic [31:0] model_result(input logic [5:0] op, input logic [31:0] a, b, c);
      if (op >= N_OPS) return 32'h0;
      return op_value(op, a, b, c);
   endfunction

   function automatic logic [31:0] stub_fn(input logic [N_OPS-1:0] oh, input logic [31:0] a, b, c);
      logic [31:0] r;
      r = 32'hBAD0BAD0;
      for (int i = 0; i < N_OPS; i++)
         if (oh == (N_OPS'(1) << i)) r = op_value(6'(i), a, b, c);
      return r;
   endfunction

   // ALU stub: result is only meaningful once flags and operands held for LAT cycles.
   logic [N_OPS-1:0] h_oh0, h_oh1;
   logic [95:0]      h_opd0, h_opd1;
   always @(posedge clk) begin
      h_oh0  <= alu_op_onehot;
      h_oh1  <= h_oh0;
      h_opd0 <= {alu_rs1, alu_rs2, alu_imm};
      h_opd1 <= h_opd0;
   end
   always_comb begin
      if (alu_op_onehot == h_oh0 && alu_op_onehot == h_oh1 &&
          {alu_rs1, alu_rs2, alu_imm} == h_opd0 && {alu_rs1, alu_rs2, alu_imm} == h_opd1)
         alu_result = stub_fn(alu_op_onehot, alu_rs1, alu_rs2, alu_imm);
      else
         alu_result = 32'hBAD0BAD0;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ex_req_valid = 0; ls_req_valid = 0; ex_rsp_ready = 0; ls_rsp_ready = 0; flush = 0;
      ex_req_op = '0; ex_req_rs1 = '0; ex_req_rs2 = '0; ex_req_imm = '0;
      ls_req_op = '0; ls_req_rs1 = '0; ls_req_rs2 = '0; ls_req_imm = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   task automatic drive_req(input bit who, input logic [5:0] op, input logic [31:0] a, b, c);
      if (who) begin
         ls_req_valid = 1; ls_req_op = op; ls_req_rs1 = a; ls_req_rs2 = b; ls_req_imm = c;
      end else begin
         ex_req_valid = 1; ex_req_op = op; ex_req_rs1 = a; ex_req_rs2 = b; ex_req_imm = c;
      end
   endtask

   // One complete op from one requester, with the other requester knocking throughout.
   task automatic run_op(input bit who, input logic [5:0] op, input logic [31:0] a, b, c, want,
                         input int hold, input string tag);
      int n;
      logic [63:0] want_oh;
      want_oh = (op < N_OPS) ? (64'd1 << op) : 64'd0;
      ex_rsp_ready = 0; ls_rsp_ready = 0;
      ex_req_valid = 0; ls_req_valid = 0;
      drive_req(who, op, a, b, c);
      n = 0;
      @(negedge clk);
      while (!(who ? ls_req_ready : ex_req_ready) && n < 20) begin
         tick(); @(negedge clk); n++;
      end
      chk({tag, "_ready"}, 64'(who ? ls_req_ready : ex_req_ready), 1);
      tick();
      if (who) begin ls_req_valid = 0; drive_req(0, OP_ADD, 1, 2, 3); end
      else     begin ex_req_valid = 0; drive_req(1, OP_LW, 4, 5, 6); end
      for (int k = 0; k < LAT; k++) begin
         @(negedge clk);
         chk({tag, "_onehot"}, 64'(alu_op_onehot), want_oh);
         chk({tag, "_early_rsp"}, 64'(ex_rsp_valid | ls_rsp_valid), 0);
         chk({tag, "_other_ready"}, 64'(who ? ex_req_ready : ls_req_ready), 0);
         tick();
      end
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, 64'(who ? ls_rsp_valid : ex_rsp_valid), 1);
         chk({tag, "_hold_other_rsp"}, 64'(who ? ex_rsp_valid : ls_rsp_valid), 0);
         chk({tag, "_hold_result"}, 64'(who ? ls_rsp_result : ex_rsp_result), 64'(want));
         chk({tag, "_hold_other_ready"}, 64'(who ? ex_req_ready : ls_req_ready), 0);
         chk({tag, "_hold_onehot"}, 64'(alu_op_onehot), 0);
         tick();
      end
      ex_req_valid = 0; ls_req_valid = 0;
      if (who) ls_rsp_ready = 1; else ex_rsp_ready = 1;
      @(negedge clk);
      chk({tag, "_rsp_valid"}, 64'(who ? ls_rsp_valid : ex_rsp_valid), 1);
      chk({tag, "_rsp_other"}, 64'(who ? ex_rsp_valid : ls_rsp_valid), 0);
      chk({tag, "_result"}, 64'(who ? ls_rsp_result : ex_rsp_result), 64'(want));
      tick();
      ex_rsp_ready = 0; ls_rsp_ready = 0;
      @(negedge clk);
      chk({tag, "_done_busy"}, 64'(busy), 0);
      chk({tag, "_done_rsp"}, 64'(ex_rsp_valid | ls_rsp_valid), 0);
      tick();
   endtask

   typedef struct {
      bit          who;
      logic [5:0]  op;
      logic [31:0] rs1, rs2, imm, exp;
      int          hold;
   } vec_t;

   vec_t        vt [8];
   int          acc_at [4];
   bit          acc_own [4];
   int          n_acc, n;
   bit          m_pend, m_own, m_last, exp_gex, exp_gls, in_resp;
   int          m_acc;
   logic [5:0]  m_op;
   logic [31:0] m_res;
   logic [63:0] exp_oh;

   initial begin
      vt[0] = '{1'b0, OP_ADDI, 32'h000000F0, 32'h0, 32'h0000000F, 32'h000000FF, 5};
      vt[1] = '{1'b1, OP_SW,   32'h3, 32'h0, 32'h4, 32'h7, 0};
      vt[2] = '{1'b0, OP_ADD,  32'h7FFFFFFF, 32'h1, 32'h0, 32'h80000000, 1};
      vt[3] = '{1'b1, OP_SUB,  32'h0, 32'h1, 32'h0, 32'hFFFFFFFF, 2};
      vt[4] = '{1'b0, 6'd63,   32'h12345678, 32'h9, 32'h1, 32'h0, 0};
      vt[5] = '{1'b1, 6'd37,   32'h11111111, 32'h2, 32'h3, 32'h0, 1};
      vt[6] = '{1'b0, OP_SW,   32'hFFFFFFFC, 32'h0, 32'h8, 32'h4, 0};
      vt[7] = '{1'b0, OP_XOR,  32'hA5A5A5A5, 32'hFFFF0000, 32'h0, 32'h5A5AA5A5, 0};

      // Reset state, with both requesters knocking during reset.
      idle_inputs();
      rst = 1;
      ex_req_valid = 1; ls_req_valid = 1;
      tick(); tick();
      @(negedge clk);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_ready", 64'({ex_req_ready, ls_req_ready}), 0);
      chk("rst_rsp", 64'({ex_rsp_valid, ls_rsp_valid}), 0);
      chk("rst_onehot", 64'(alu_op_onehot), 0);
      chk("rst_operands", 64'(alu_rs1 | alu_rs2 | alu_imm), 0);
      chk("rst_results", 64'(ex_rsp_result | ls_rsp_result), 0);
      tick();
      idle_inputs();
      rst = 0;
      @(negedge clk);
      chk("idle_ready", 64'({ex_req_ready, ls_req_ready}), 0);
      tick();

      for (int i = 0; i < 8; i++)
         run_op(vt[i].who, vt[i].op, vt[i].rs1, vt[i].rs2, vt[i].imm, vt[i].exp, vt[i].hold,
                $sformatf("vec%0d", i));

      // Round-robin with both requesters valid and responses always taken.
      do_reset();
      drive_req(0, OP_ADD, 32'h10, 32'h20, 32'h0);
      drive_req(1, OP_SW, 32'h100, 32'h0, 32'h4);
      ex_rsp_ready = 1; ls_rsp_ready = 1;
      n_acc = 0;
      for (int c = 0; c < 40 && n_acc < 4; c++) begin
         @(negedge clk);
         if (ex_req_ready && ls_req_ready) chk("arb_both_ready", 1, 0);
         if (ex_req_ready || ls_req_ready) begin
            acc_own[n_acc] = ls_req_ready;
            acc_at[n_acc]  = cyc;
            n_acc++;
         end
         tick();
      end
      ex_req_valid = 0; ls_req_valid = 0;
      chk("arb_count", 64'(n_acc), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("arb_owner%0d", i), 64'(acc_own[i]), 64'(i % 2));
      for (int i = 1; i < 4; i++) chk($sformatf("arb_gap%0d", i), 64'(acc_at[i] - acc_at[i-1]), LAT + 2);
      n = 0;
      while (busy && n < 20) begin tick(); n++; end
      chk("arb_drain", 64'(busy), 0);

      // Flush during EXEC with a second EX request waiting behind it.
      idle_inputs();
      ex_rsp_ready = 1;
      drive_req(0, OP_ADD, 32'd10, 32'd20, 32'd0);
      @(negedge clk);
      chk("fl_ready", 64'(ex_req_ready), 1);
      tick();
      drive_req(0, OP_SUB, 32'd100, 32'd1, 32'd0);
      @(negedge clk);
      chk("fl_busy", 64'(busy), 1);
      tick();
      flush = 1;
      @(negedge clk);
      chk("fl_ready_gated", 64'(ex_req_ready), 0);
      chk("fl_rsp0", 64'(ex_rsp_valid), 0);
      tick();
      flush = 0;
      @(negedge clk);
      chk("fl_idle", 64'(busy), 0);
      chk("fl_rsp1", 64'(ex_rsp_valid), 0);
      chk("fl_reaccept", 64'(ex_req_ready), 1);
      tick();
      ex_req_valid = 0;
      for (int k = 0; k < LAT; k++) begin
         @(negedge clk);
         chk("fl_no_rsp", 64'(ex_rsp_valid), 0);
         tick();
      end
      @(negedge clk);
      chk("fl_rsp_valid", 64'(ex_rsp_valid), 1);
      chk("fl_result", 64'(ex_rsp_result), 64'd99);
      tick();

      // Flush while a response is being held off.
      idle_inputs();
      drive_req(1, OP_ADDI, 32'd5, 32'd0, 32'd6);
      @(negedge clk);
      chk("flr_ready", 64'(ls_req_ready), 1);
      tick();
      ls_req_valid = 0;
      for (int k = 0; k < LAT; k++) tick();
      @(negedge clk);
      chk("flr_rsp_valid", 64'(ls_rsp_valid), 1);
      chk("flr_result", 64'(ls_rsp_result), 64'd11);
      tick();
      flush = 1;
      @(negedge clk);
      chk("flr_still_valid", 64'(ls_rsp_valid), 1);
      tick();
      flush = 0;
      @(negedge clk);
      chk("flr_dropped", 64'(ls_rsp_valid), 0);
      chk("flr_idle", 64'(busy), 0);
      tick();

      // Random traffic against a timestamp-based transaction model.
      do_reset();
      m_pend = 0; m_last = 1; m_acc = 0; m_own = 0; m_op = '0; m_res = '0;
      for (int c = 0; c < 1500; c++) begin
         rst          = ($urandom_range(0, 199) == 0);
         flush        = ($urandom_range(0, 29) == 0);
         ex_req_valid = $urandom_range(0, 1);
         ls_req_valid = $urandom_range(0, 1);
         ex_rsp_ready = ($urandom_range(0, 4) < 3);
         ls_rsp_ready = ($urandom_range(0, 4) < 3);
         ex_req_op  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(37, 63)) : 6'($urandom_range(0, 36));
         ls_req_op  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(37, 63)) : 6'($urandom_range(0, 36));
         ex_req_rs1 = $urandom; ex_req_rs2 = $urandom; ex_req_imm = $urandom;
         ls_req_rs1 = $urandom; ls_req_rs2 = $urandom; ls_req_imm = $urandom;
         @(negedge clk);
         exp_gex = !rst && !m_pend && !flush && ex_req_valid && (!ls_req_valid || m_last);
         exp_gls = !rst && !m_pend && !flush && ls_req_valid && (!ex_req_valid || !m_last);
         in_resp = m_pend && (cyc >= m_acc + LAT);
         exp_oh  = (m_pend && !in_resp && m_op < N_OPS) ? (64'd1 << m_op) : 64'd0;
         chk("rnd_ex_ready", 64'(ex_req_ready), 64'(exp_gex));
         chk("rnd_ls_ready", 64'(ls_req_ready), 64'(exp_gls));
         chk("rnd_ex_rsp", 64'(ex_rsp_valid), 64'(in_resp && !m_own));
         chk("rnd_ls_rsp", 64'(ls_rsp_valid), 64'(in_resp && m_own));
         chk("rnd_busy", 64'(busy), 64'(m_pend));
         chk("rnd_onehot", 64'(alu_op_onehot), exp_oh);
         if (in_resp)
            chk("rnd_result", 64'(m_own ? ls_rsp_result : ex_rsp_result), 64'(m_res));
         if (rst) begin
            m_pend = 0; m_last = 1;
         end else if (flush) begin
            m_pend = 0;
         end else if (exp_gex || exp_gls) begin
            m_pend = 1; m_acc = cyc + 1; m_own = exp_gls; m_last = exp_gls;
            m_op   = exp_gls ? ls_req_op : ex_req_op;
            m_res  = exp_gls ? model_result(ls_req_op, ls_req_rs1, ls_req_rs2, ls_req_imm)
                             : model_result(ex_req_op, ex_req_rs1, ex_req_rs2, ex_req_imm);
         end else if (in_resp && (m_own ? ls_rsp_ready : ex_rsp_ready)) begin
            m_pend = 0;
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
